pad_bus_ctrl: RTL and testbench

- Half-duplex controller that sits directly upstream of a row of WIDTH PADBID bidirectional pad cells.
- Drives each cell's I and OEN pins and samples each cell's C pin.
- Serialises core-side write words and read requests into pad drive/release windows, with turnaround gaps between them.
- Flags bus contention when the pad value read back during a drive does not match the driven value.

---
 rtl/pad_bus_pkg.sv | 25 ++
 rtl/pad_bus_cnt.sv | 26 ++
 rtl/pad_bus_ctrl.sv | 129 ++++++++++++
 tb/tb_pad_bus_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pad_bus_pkg.sv
// Shared types and defaults for the PADBID bus controller.
package pad_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_TURN,
    S_TX_DRIVE,
    S_RX_TURN,
    S_RX_WAIT
  } state_t;

  localparam logic OEN_RELEASE = 1'b1;
  localparam logic OEN_DRIVE   = 1'b0;

  localparam int DEF_TURN_CYC   = 1;
  localparam int DEF_HOLD_CYC   = 2;
  localparam int DEF_SAMPLE_DLY = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pad_bus_cnt.sv
// Loadable down-counter shared by every timed state of the pad bus FSM.
module pad_bus_cnt #(
  parameter int CW = 2
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt > CW'(1)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == CW'(1));

endmodule

// File: rtl/pad_bus_ctrl.sv
// Half-duplex PADBID row controller: serialises writes and reads into
// drive/release windows with turnaround gaps and flags contention.
module pad_bus_ctrl
  import pad_bus_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int TURN_CYC   = DEF_TURN_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int SAMPLE_DLY = DEF_SAMPLE_DLY
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  input  logic             rx_req,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_oen,
  input  logic [WIDTH-1:0] pad_c,
  output logic             busy,
  output logic             err,
  input  logic             err_clr
);

  // Write turnaround is one cycle longer: pad_i settles a cycle before OEN falls.
  localparam int TX_TURN = TURN_CYC + 1;
  localparam int CW =
    $clog2(max3(TX_TURN, HOLD_CYC, SAMPLE_DLY) + 1);

  state_t        state;
  state_t        state_n;
  logic          rx_pend;
  logic          load;
  logic [CW-1:0] load_val;
  logic          done;

  pad_bus_cnt #(.CW(CW)) u_cnt (
    .CK       (CK),
    .RST      (RST),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_val = '0;
    unique case (state)
      S_IDLE: begin
        if (rx_pend || (!tx_valid && rx_req)) begin
          state_n  = S_RX_TURN;
          load     = 1'b1;
          load_val = CW'(TURN_CYC);
        end else if (tx_valid) begin
          state_n  = S_TX_TURN;
          load     = 1'b1;
          load_val = CW'(TX_TURN);
        end
      end
      S_TX_TURN: begin
        if (done) begin
          state_n  = S_TX_DRIVE;
          load     = 1'b1;
          load_val = CW'(HOLD_CYC);
        end
      end
      S_TX_DRIVE: begin
        if (done) state_n = S_IDLE;
      end
      S_RX_TURN: begin
        if (done) begin
          state_n  = S_RX_WAIT;
          load     = 1'b1;
          load_val = CW'(SAMPLE_DLY);
        end
      end
      S_RX_WAIT: begin
        if (done) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      pad_oen  <= {WIDTH{OEN_RELEASE}};
      pad_i    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_pend  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      rx_valid <= 1'b0;
      if (rx_req) rx_pend <= 1'b1;
      if (err_clr) err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!rx_pend && tx_valid) pad_i <= tx_data;
        end
        S_TX_TURN: begin
          if (done) pad_oen <= {WIDTH{OEN_DRIVE}};
        end
        S_TX_DRIVE: begin
          if (done) begin
            pad_oen <= {WIDTH{OEN_RELEASE}};
            if (pad_c !== pad_i) err <= 1'b1;
          end
        end
        S_RX_WAIT: begin
          if (done) begin
            rx_data  <= pad_c;
            rx_valid <= 1'b1;
            rx_pend  <= rx_req;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_ready = (state == S_IDLE) & ~rx_pend;
  assign busy     = (state != S_IDLE) | rx_pend;

endmodule

// File: tb/tb_pad_bus_ctrl.sv
// Random and directed bench for pad_bus_ctrl against a timeline model
// built from the write/read window arithmetic.
module tb_pad_bus_ctrl;

  localparam int W = 4;
  localparam int T = 1;
  localparam int H = 2;
  localparam int S = 2;

  logic         CK = 1'b0;
  logic         RST = 1'b1;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_ready;
  logic         rx_req = 1'b0;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  logic [W-1:0] pad_i;
  logic [W-1:0] pad_oen;
  logic [W-1:0] pad_c;
  logic         busy;
  logic         err;
  logic         err_clr = 1'b0;

  logic         loop = 1'b1;
  logic [W-1:0] fval = '0;

  assign pad_c = loop ? pad_i : fval;

  pad_bus_ctrl #(
    .WIDTH(W), .TURN_CYC(T), .HOLD_CYC(H), .SAMPLE_DLY(S)
  ) dut (
    .CK(CK), .RST(RST),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_req(rx_req), .rx_valid(rx_valid), .rx_data(rx_data),
    .pad_i(pad_i), .pad_oen(pad_oen), .pad_c(pad_c),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 CK = ~CK;

  int n_chk = 0;
  int n_fail = 0;

  // model: op timeline in edge numbers since reset release
  int           e;
  int           op_end;
  int           drv;
  bit           op_wr;
  bit           m_pend;
  bit           m_err;
  bit           m_rxv;
  bit           m_acc;
  logic [W-1:0] m_word;
  logic [W-1:0] m_rxd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  task automatic mdl_reset();
    e = 0; op_end = 0; drv = 0; op_wr = 0;
    m_pend = 0; m_err = 0; m_rxv = 0; m_acc = 0;
    m_word = '0; m_rxd = '0;
  endtask

  task automatic start_rd(input int at);
    op_wr  = 0;
    op_end = at + T + S;
  endtask

  task automatic check_all();
    bit idle;
    logic [W-1:0] oen_x;
    idle  = (e >= op_end);
    oen_x = (op_wr && e >= drv && e < op_end) ? '0 : '1;
    chk("pad_oen", 32'(pad_oen), 32'(oen_x));
    chk("pad_i", 32'(pad_i), 32'(m_word));
    chk("tx_ready", 32'(tx_ready), 32'(idle && !m_pend));
    chk("busy", 32'(busy), 32'(!idle || m_pend));
    chk("err", 32'(err), 32'(m_err));
    chk("rx_valid", 32'(rx_valid), 32'(m_rxv));
    chk("rx_data", 32'(rx_data), 32'(m_rxd));
  endtask

  task automatic step();
    bit idle_b;
    bit pend_b;
    logic [W-1:0] pcv;
    @(posedge CK);
    e++;
    idle_b = (e - 1 >= op_end);
    pend_b = m_pend;
    m_rxv  = 0;
    m_acc  = 0;
    pcv    = loop ? m_word : fval;
    if (err_clr) m_err = 0;
    if (rx_req) m_pend = 1;
    if (!idle_b && e == op_end) begin
      if (op_wr) begin
        if (pcv !== m_word) m_err = 1;
      end else begin
        m_rxd  = pcv;
        m_rxv  = 1;
        m_pend = rx_req;
      end
    end
    if (idle_b) begin
      if (pend_b) begin
        start_rd(e);
      end else if (tx_valid) begin
        m_word = tx_data;
        m_acc  = 1;
        op_wr  = 1;
        drv    = e + T + 1;
        op_end = e + T + H + 1;
      end else if (rx_req) begin
        start_rd(e);
      end
    end
    @(negedge CK);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // offer one word and keep it up until the model sees it accepted
  task automatic write_word(input logic [W-1:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_acc) break;
    end
    if (!m_acc) chk("tx_accept_timeout", 32'(0), 32'(1));
    tx_valid = 1'b0;
  endtask

  initial begin
    mdl_reset();
    RST = 1'b1;
    repeat (3) @(posedge CK);
    @(negedge CK);
    chk("rst_oen", 32'(pad_oen), 32'hF);
    chk("rst_pad_i", 32'(pad_i), 32'h0);
    chk("rst_tx_ready", 32'(tx_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    RST = 1'b0;
    steps(2);

    // single looped-back write
    loop = 1'b1;
    write_word(4'hA);
    steps(6);

    // contention: pads read back 4'h4 while 4'h5 is driven
    loop = 1'b0;
    fval = 4'h4;
    write_word(4'h5);
    steps(14);
    chk("err_sticky", 32'(err), 32'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    steps(2);
    chk("err_cleared", 32'(err), 32'h0);

    // read from idle
    fval = 4'h3;
    rx_req = 1'b1;
    step();
    rx_req = 1'b0;
    steps(6);
    chk("rd_data", 32'(rx_data), 32'h3);

    // read requested mid-drive while the next write waits
    loop = 1'b1;
    write_word(4'hC);
    while (e < drv) step();
    rx_req = 1'b1;
    step();
    rx_req = 1'b0;
    write_word(4'h7);
    steps(6);

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      if (m_acc || !tx_valid) begin
        tx_valid = ($urandom_range(0, 2) == 0);
        tx_data  = W'($urandom);
      end
      rx_req  = ($urandom_range(0, 9) == 0);
      err_clr = ($urandom_range(0, 19) == 0);
      loop    = ($urandom_range(0, 4) != 0);
      fval    = W'($urandom);
      step();
    end
    tx_valid = 1'b0;
    rx_req   = 1'b0;
    err_clr  = 1'b0;
    loop     = 1'b1;
    steps(10);

    // reset while driving, with a read pending
    write_word(4'h9);
    while (e < drv) step();
    rx_req = 1'b1;
    step();
    rx_req = 1'b0;
    chk("pre_rst_oen", 32'(pad_oen), 32'h0);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_oen", 32'(pad_oen), 32'hF);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    mdl_reset();
    @(negedge CK);
    RST = 1'b0;
    steps(3);
    chk("post_rst_ready", 32'(tx_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
